// File: rtl/seq_div_8_8_if.sv
// Operand/result handshake bundle for the sequential unsigned divider.
// The master drives operands and out_ready; the slave (divider) returns results.
interface seq_div_8_8_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div_8_8.sv
// Radix-2 restoring unsigned divider, one quotient bit per clock.
// Optional SEQ_DIV_BYPASS_EN: b==0 or a<b completes straight from IDLE to DONE.
module seq_div_8_8 #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_div_8_8_if.slave    bus,
  output logic [1:0]      dbg_state
);
  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1. in_ready depends on state only; results hold while out_valid && !out_ready.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic             dbz_q;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_sub;
  logic             take;
  logic             skip;

  // WIDTH+1 bits keep the carry when the divisor has its MSB set.
  assign r_shift = {rem_q, dvd_q[WIDTH-1]};
  assign r_sub   = r_shift - {1'b0, dvs_q};
  assign take    = (r_shift >= {1'b0, dvs_q});

`ifdef SEQ_DIV_BYPASS_EN
  assign skip = (bus.b == '0) || (bus.a < bus.b);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = skip ? DONE : BUSY;
      BUSY: if (cnt_q == CW'(WIDTH - 1)) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dvd_q <= bus.a;
            dvs_q <= bus.b;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            dbz_q <= (bus.b == '0);
            if (skip) begin
              quo_q <= (bus.b == '0) ? '1 : '0;
              rem_q <= bus.a;
            end
          end
        end
        BUSY: begin
          rem_q <= take ? r_sub[WIDTH-1:0] : r_shift[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], take};
          dvd_q <= dvd_q << 1;
          cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign dbg_state       = state;
endmodule
